// File: rtl/bft_leaf_port.sv
// PE-side leaf endpoint of the butterfly-fat-tree: TX FIFO with resend hold,
// RX FIFO fed by the network and by local loopback of self-addressed packets.
module bft_leaf_port #(
    parameter int NUM_LEAVES = 16,
    parameter int PAYLOAD_SZ = 44,
    parameter int SELF_ADDR  = 0,
    parameter int TX_DEPTH   = 8,
    parameter int RX_DEPTH   = 8,
    localparam int ADDR_W    = $clog2(NUM_LEAVES),
    localparam int P_SZ      = 1 + ADDR_W + PAYLOAD_SZ
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [PAYLOAD_SZ-1:0] in_data,
    input  logic [ADDR_W-1:0]     in_dest,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [PAYLOAD_SZ-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [P_SZ-1:0]       dout_leaf,
    input  logic [P_SZ-1:0]       din_leaf,
    input  logic                  resend,
    output logic [15:0]           drop_cnt,
    output logic [15:0]           retry_cnt
);
    localparam int TXA  = $clog2(TX_DEPTH);
    localparam int RXA  = $clog2(RX_DEPTH);
    localparam int E_SZ = ADDR_W + PAYLOAD_SZ;
    localparam logic [ADDR_W-1:0] SELF = ADDR_W'(SELF_ADDR);

    logic [E_SZ-1:0]       tx_mem [TX_DEPTH];
    logic [PAYLOAD_SZ-1:0] rx_mem [RX_DEPTH];

    logic [TXA:0]      tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [RXA:0]      rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    logic [P_SZ-1:0]   dout_q, dout_d;
    logic [15:0]       drop_q, drop_d, retry_q, retry_d;

    logic tx_full, tx_empty, tx_push, tx_pop;
    logic rx_full, rx_empty, rx_push, rx_pop, rx_space;
    logic hold, head_self, din_valid, loop_ok, drop;
    logic [E_SZ-1:0]       tx_head;
    logic [ADDR_W-1:0]     head_dest;
    logic [PAYLOAD_SZ-1:0] head_pl, rx_wdata;
    logic                  din_dest_unused;

    assign tx_empty = tx_wp_q == tx_rp_q;
    assign tx_full  = (tx_wp_q[TXA-1:0] == tx_rp_q[TXA-1:0])
                   && (tx_wp_q[TXA] != tx_rp_q[TXA]);
    assign rx_empty = rx_wp_q == rx_rp_q;
    assign rx_full  = (rx_wp_q[RXA-1:0] == rx_rp_q[RXA-1:0])
                   && (rx_wp_q[RXA] != rx_rp_q[RXA]);

    assign in_ready  = !tx_full;
    assign out_valid = !rx_empty;
    assign out_data  = rx_mem[rx_rp_q[RXA-1:0]];
    assign dout_leaf = dout_q;
    assign drop_cnt  = drop_q;
    assign retry_cnt = retry_q;

    assign tx_head   = tx_mem[tx_rp_q[TXA-1:0]];
    assign head_dest = tx_head[E_SZ-1 -: ADDR_W];
    assign head_pl   = tx_head[PAYLOAD_SZ-1:0];
    assign head_self = head_dest == SELF;
    assign din_valid = din_leaf[P_SZ-1];
    // Arrivals are not routed on, so their dest field carries no meaning here
    assign din_dest_unused = ^din_leaf[P_SZ-2 -: ADDR_W];

    // A same-edge RX pop frees a slot for the incoming write
    assign rx_pop   = out_valid && out_ready;
    assign rx_space = !rx_full || rx_pop;

    assign hold    = resend && dout_q[P_SZ-1];
    assign tx_push = in_valid && !tx_full;
    assign loop_ok = !din_valid && rx_space;
    assign tx_pop  = !hold && !tx_empty && (!head_self || loop_ok);

    always_comb begin
        rx_push  = 1'b0;
        rx_wdata = din_leaf[PAYLOAD_SZ-1:0];
        drop     = 1'b0;
        if (din_valid) begin
            rx_push = rx_space;
            drop    = !rx_space;
        end else if (tx_pop && head_self) begin
            rx_push  = 1'b1;
            rx_wdata = head_pl;
        end
    end

    always_comb begin
        dout_d  = '0;
        retry_d = retry_q;
        drop_d  = drop_q;
        tx_wp_d = tx_wp_q;
        tx_rp_d = tx_rp_q;
        rx_wp_d = rx_wp_q;
        rx_rp_d = rx_rp_q;
        if (hold) begin
            dout_d = dout_q;
            if (retry_q != 16'hFFFF) retry_d = retry_q + 16'd1;
        end else if (tx_pop && !head_self) begin
            dout_d = {1'b1, tx_head};
        end
        if (drop && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
        if (tx_push) tx_wp_d = tx_wp_q + 1'b1;
        if (tx_pop)  tx_rp_d = tx_rp_q + 1'b1;
        if (rx_push) rx_wp_d = rx_wp_q + 1'b1;
        if (rx_pop)  rx_rp_d = rx_rp_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout_q  <= '0;
            retry_q <= '0;
            drop_q  <= '0;
            tx_wp_q <= '0;
            tx_rp_q <= '0;
            rx_wp_q <= '0;
            rx_rp_q <= '0;
        end else begin
            dout_q  <= dout_d;
            retry_q <= retry_d;
            drop_q  <= drop_d;
            tx_wp_q <= tx_wp_d;
            tx_rp_q <= tx_rp_d;
            rx_wp_q <= rx_wp_d;
            rx_rp_q <= rx_rp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wp_q[TXA-1:0]] <= {in_dest, in_data};
        if (rx_push) rx_mem[rx_wp_q[RXA-1:0]] <= rx_wdata;
    end
endmodule
